// File: rtl/sha1_pkg.sv
// ---------------------------------------------------------------------------
// sha1_pkg
// Shared constants and types for the SHA-1 message padder.
//   SHA1_BLOCK_WORDS : words per 512-bit block
//   SHA1_WIDX_W      : width of the in-block word index
//   SHA1_LEN_HI_IDX  : block index where the 64-bit length begins
//   SHA1_PAD_WORD    : 0x80 marker byte followed by zeros
//   pad_state_t      : padder sequencing states
//   byte_bits()      : converts a byte count (0..4) into a bit count
// ---------------------------------------------------------------------------
package sha1_pkg;

    localparam int SHA1_BLOCK_WORDS = 16;
    localparam int SHA1_WIDX_W      = $clog2(SHA1_BLOCK_WORDS);

    localparam logic [SHA1_WIDX_W-1:0] SHA1_LEN_HI_IDX = SHA1_WIDX_W'(14);
    localparam logic [31:0]            SHA1_PAD_WORD   = 32'h8000_0000;

    typedef enum logic [2:0] {
        DATA,
        PAD80,
        ZERO,
        LENHI,
        LENLO
    } pad_state_t;

    // A byte count of 0..4 is at most 32 bits, so 6 bits hold the result.
    function automatic logic [5:0] byte_bits(input logic [2:0] nbytes);
        return {nbytes, 3'b000};
    endfunction

endpackage

// File: rtl/sha1_pad_if.sv
// ---------------------------------------------------------------------------
// sha1_pad_if
// Bundles the message input stream and the padded output stream of the
// SHA-1 padder.
//   in_data/in_bytes/in_last/in_valid/in_ready : message word stream
//   out_data/out_first/out_final/out_valid/out_ready : padded word stream
// Modports:
//   master : the environment (drives message words, consumes padded words)
//   slave  : the padder itself
// ---------------------------------------------------------------------------
interface sha1_pad_if;

    logic [31:0] in_data;
    logic [2:0]  in_bytes;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;

    logic [31:0] out_data;
    logic        out_first;
    logic        out_final;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output in_data, in_bytes, in_last, in_valid,
        input  in_ready,
        input  out_data, out_first, out_final, out_valid,
        output out_ready
    );

    modport slave (
        input  in_data, in_bytes, in_last, in_valid,
        output in_ready,
        output out_data, out_first, out_final, out_valid,
        input  out_ready
    );

endinterface

// File: rtl/sha1_pad_mask.sv
// ---------------------------------------------------------------------------
// sha1_pad_mask
// Combinational: keeps the first in_bytes bytes of a big-endian word and
// places the 0x80 marker byte directly after them, zeroing the rest.
//   in_data  : message word, byte 0 in [31:24]
//   in_bytes : number of valid bytes (0..4); 4 passes the word unchanged
//   masked   : word with trailing bytes replaced by 0x80, 0x00...
// ---------------------------------------------------------------------------
module sha1_pad_mask
    import sha1_pkg::*;
(
    input  logic [31:0] in_data,
    input  logic [2:0]  in_bytes,
    output logic [31:0] masked
);

    // The marker and trailing zeros are just the top bits of the pad word.
    always_comb begin
        masked = in_data;
        case (in_bytes)
            3'd0:    masked = SHA1_PAD_WORD;
            3'd1:    masked = {in_data[31:24], SHA1_PAD_WORD[31:8]};
            3'd2:    masked = {in_data[31:16], SHA1_PAD_WORD[31:16]};
            3'd3:    masked = {in_data[31:8],  SHA1_PAD_WORD[31:24]};
            default: masked = in_data;
        endcase
    end

endmodule

// File: rtl/sha1_pad.sv
// ---------------------------------------------------------------------------
// sha1_pad
// SHA-1 message padder. Takes a byte message as big-endian 32-bit words and
// emits the padded stream (message, 0x80, zeros, 64-bit bit length) in
// 16-word blocks, flagging the first word of every block and the last word
// of the message's final block.
// Parameters:
//   LEN_W : width of the bit-length counter (<= 64, zero-extended on output)
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sha1_pad_if.slave (message input and padded output streams)
// ---------------------------------------------------------------------------
module sha1_pad
    import sha1_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    sha1_pad_if.slave  bus
);

    pad_state_t             state, state_d;
    logic [SHA1_WIDX_W-1:0] widx, widx_d;
    logic [LEN_W-1:0]       len, len_d;
    logic [63:0]            len64;

    logic [31:0] out_data_q;
    logic        out_first_q;
    logic        out_final_q;
    logic        out_valid_q;

    logic        load;
    logic        accept;
    logic        emit;
    logic        emit_final;
    logic [31:0] emit_data;
    logic [31:0] masked;

    sha1_pad_mask u_mask (
        .in_data  (bus.in_data),
        .in_bytes (bus.in_bytes),
        .masked   (masked)
    );

    // The output register may take a new word whenever it is empty or its
    // current word is being consumed this cycle.
    assign load   = !out_valid_q || bus.out_ready;

    // Gating with rst_n keeps in_ready low while reset is held, since the
    // registered terms alone would already allow an accept.
    assign bus.in_ready = rst_n && (state == DATA) && load;
    assign accept       = bus.in_valid && bus.in_ready;

    assign len64 = 64'(len);

    assign bus.out_data  = out_data_q;
    assign bus.out_first = out_first_q;
    assign bus.out_final = out_final_q;
    assign bus.out_valid = out_valid_q;

    // Next-state and emit decision. Every emit happens only on a load, so
    // widx counts exactly the words written into the output register.
    always_comb begin
        state_d    = state;
        widx_d     = widx;
        len_d      = len;
        emit       = 1'b0;
        emit_final = 1'b0;
        emit_data  = '0;

        case (state)
            DATA: begin
                if (accept) begin
                    if (!bus.in_last) begin
                        emit      = 1'b1;
                        emit_data = bus.in_data;
                        len_d     = len + LEN_W'(32);
                    end else if (bus.in_bytes == 3'd0) begin
                        // Empty tail word: the marker goes out as its own word.
                        state_d = PAD80;
                    end else if (bus.in_bytes >= 3'd4) begin
                        emit      = 1'b1;
                        emit_data = bus.in_data;
                        len_d     = len + LEN_W'(32);
                        state_d   = PAD80;
                    end else begin
                        emit      = 1'b1;
                        emit_data = masked;
                        len_d     = len + LEN_W'(byte_bits(bus.in_bytes));
                        state_d   = ZERO;
                    end
                end
            end

            PAD80: begin
                if (load) begin
                    emit      = 1'b1;
                    emit_data = SHA1_PAD_WORD;
                    state_d   = ZERO;
                end
            end

            ZERO: begin
                // Zero fill runs through a block wrap if needed, stopping
                // when the next slot is where the length belongs.
                if (load) begin
                    if (widx == SHA1_LEN_HI_IDX) begin
                        state_d = LENHI;
                    end else begin
                        emit      = 1'b1;
                        emit_data = '0;
                    end
                end
            end

            LENHI: begin
                if (load) begin
                    emit      = 1'b1;
                    emit_data = len64[63:32];
                    state_d   = LENLO;
                end
            end

            LENLO: begin
                if (load) begin
                    emit       = 1'b1;
                    emit_final = 1'b1;
                    emit_data  = len64[31:0];
                    len_d      = '0;
                    state_d    = DATA;
                end
            end

            default: begin
                state_d = DATA;
            end
        endcase

        if (emit_final) begin
            widx_d = '0;
        end else if (emit) begin
            widx_d = widx + 1'b1;
        end
    end

    // State, counters and the single output stage. A load with nothing to
    // emit simply empties the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= DATA;
            widx        <= '0;
            len         <= '0;
            out_data_q  <= '0;
            out_first_q <= 1'b0;
            out_final_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state <= state_d;
            widx  <= widx_d;
            len   <= len_d;
            if (load) begin
                out_valid_q <= emit;
                if (emit) begin
                    out_data_q  <= emit_data;
                    out_first_q <= (widx == '0);
                    out_final_q <= emit_final;
                end
            end
        end
    end

endmodule

// File: tb/tb_sha1_pad.sv
// ---------------------------------------------------------------------------
// tb_sha1_pad
// Directed bench for sha1_pad: a table of messages with hand-computed pad
// words and length words, run with a free-flowing and a randomly stalling
// consumer, plus reset-state and mid-block reset sequences.
// ---------------------------------------------------------------------------
module tb_sha1_pad;
    import sha1_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sha1_pad_if bus ();

    sha1_pad #(.LEN_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] seed;
        int          nwords;
        logic [2:0]  last_bytes;
        int          exp_total;
        int          exp_pad_idx;
        logic [31:0] exp_pad_word;
        logic [31:0] exp_len_lo;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        first;
        logic        fin;
    } cap_t;

    vec_t tbl [8];
    cap_t cap [$];
    cap_t prev;

    int checks     = 0;
    int errors     = 0;
    bit stall_mode = 1'b0;
    bit in_pad     = 1'b0;
    bit prev_hold  = 1'b0;

    // Consumer: always ready, or a coin flip each cycle in stall mode.
    always @(posedge clk) begin
        #1;
        bus.out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor at the falling edge: collects taken words, checks that a
    // stalled word holds still, and that no word is accepted while padding.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_hold) begin
                checks++;
                if (!bus.out_valid || bus.out_data !== prev.data ||
                    bus.out_first !== prev.first || bus.out_final !== prev.fin) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: got v=%b d=%h, required v=1 d=%h",
                             bus.out_valid, bus.out_data, prev.data);
                end
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev      = '{bus.out_data, bus.out_first, bus.out_final};
            if (bus.out_valid && bus.out_ready)
                cap.push_back('{bus.out_data, bus.out_first, bus.out_final});
            if (bus.out_valid && bus.out_final)
                in_pad = 1'b0;
            if (in_pad) begin
                checks++;
                if (bus.in_ready) begin
                    errors++;
                    $display("[TB] FAIL in_ready_pad: got in_ready=1, required 0");
                end
            end
            if (bus.in_valid && bus.in_ready && bus.in_last)
                in_pad = 1'b1;
            if (bus.in_valid)
                assert (bus.in_bytes == 3'd4 || (bus.in_last && bus.in_bytes <= 3'd4))
                    else $error("[TB] illegal in_bytes %0d", bus.in_bytes);
        end else begin
            prev_hold = 1'b0;
            in_pad    = 1'b0;
        end
    end

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Offer one word and wait (bounded) until it is taken.
    task automatic sendWord(input logic [31:0] d, input logic [2:0] b, input bit last);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_bytes = b;
        bus.in_last  = last;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got no in_ready, required accept of %h", d);
        end
    endtask

    task automatic applyStimulus(input int v);
        for (int w = 0; w < tbl[v].nwords; w++) begin
            sendWord(tbl[v].seed + 32'(w) * 32'h0101_0101,
                     (w == tbl[v].nwords - 1) ? tbl[v].last_bytes : 3'd4,
                     w == tbl[v].nwords - 1);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic checkOutput(input int v);
        logic [31:0] exp_d;
        logic [31:0] flags;
        for (int c = 0; c < 2000 && cap.size() < tbl[v].exp_total; c++)
            @(negedge clk);
        repeat (4) @(negedge clk);
        checkValue($sformatf("%s count", tbl[v].name), 32'(cap.size()), 32'(tbl[v].exp_total));
        for (int i = 0; i < tbl[v].exp_total && i < cap.size(); i++) begin
            if (i < tbl[v].exp_pad_idx)
                exp_d = tbl[v].seed + 32'(i) * 32'h0101_0101;
            else if (i == tbl[v].exp_pad_idx)
                exp_d = tbl[v].exp_pad_word;
            else if (i == tbl[v].exp_total - 1)
                exp_d = tbl[v].exp_len_lo;
            else
                exp_d = 32'h0;
            checkValue($sformatf("%s w%0d data", tbl[v].name, i), cap[i].data, exp_d);
            flags = {30'b0, cap[i].first, cap[i].fin};
            checkValue($sformatf("%s w%0d first/final", tbl[v].name, i), flags,
                       {30'b0, (i % 16) == 0, i == tbl[v].exp_total - 1});
        end
        cap.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no completion, required $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //          name       seed          nw  k     tot pad  pad word      len lo
        tbl[0] = '{"abc",     32'h61626300,  1, 3'd3, 16,  0, 32'h61626380, 32'h0000_0018};
        tbl[1] = '{"empty",   32'hDEADBEEF,  1, 3'd0, 16,  0, SHA1_PAD_WORD, 32'h0000_0000};
        tbl[2] = '{"bytes56", 32'h00010203, 14, 3'd4, 32, 14, SHA1_PAD_WORD, 32'h0000_01C0};
        tbl[3] = '{"bytes64", 32'h40000000, 16, 3'd4, 32, 16, SHA1_PAD_WORD, 32'h0000_0200};
        tbl[4] = '{"bytes5",  32'h11223344,  2, 3'd1, 16,  1, 32'h12800000, 32'h0000_0028};
        tbl[5] = '{"bytes55", 32'h10000000, 14, 3'd3, 16, 13, 32'h1D0D0D80, 32'h0000_01B8};
        tbl[6] = '{"bytes60", 32'h20000000, 15, 3'd4, 32, 15, SHA1_PAD_WORD, 32'h0000_01E0};
        tbl[7] = '{"bytes62", 32'h30000000, 16, 3'd2, 32, 15, 32'h3F0F8000, 32'h0000_01F0};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_bytes  = 3'd0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        #12;
        checkValue("reset out_valid", 32'(bus.out_valid), 32'h0);
        checkValue("reset out_data",  bus.out_data,       32'h0);
        checkValue("reset out_first", 32'(bus.out_first), 32'h0);
        checkValue("reset out_final", 32'(bus.out_final), 32'h0);
        checkValue("reset in_ready",  32'(bus.in_ready),  32'h0);

        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int mode = 0; mode < 2; mode++) begin
            stall_mode = (mode == 1);
            $display("[TB] pass with stall_mode=%0d", mode);
            for (int v = 0; v < 8; v++) begin
                applyStimulus(v);
                checkOutput(v);
            end
        end
        stall_mode = 1'b0;
        @(posedge clk);
        #1;

        // Reset while word 7 of a block sits in the output register.
        for (int w = 0; w < 8; w++)
            sendWord(32'hC0DE_0000 + 32'(w), 3'd4, 1'b0);
        bus.in_valid = 1'b0;
        checkValue("pre-reset out_valid", 32'(bus.out_valid), 32'h1);
        checkValue("pre-reset out_data",  bus.out_data,       32'hC0DE_0007);
        #2 rst_n = 1'b0;
        #1;
        checkValue("async reset out_valid", 32'(bus.out_valid), 32'h0);
        checkValue("async reset in_ready",  32'(bus.in_ready),  32'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        cap.delete();
        @(posedge clk);
        #1;
        applyStimulus(0);
        checkOutput(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha1_pad.md
Name: sha1_pad

Overview:
- Upstream producer for the SHA-1 message-schedule shift register.
- Accepts an arbitrary-length byte message as big-endian 32-bit words.
- Emits the FIPS 180-4 padded stream: message bytes, then 0x80, then zeros, then a 64-bit bit length. Output is grouped into 16-word (512-bit) blocks.
- Marks block boundaries so the schedule/round logic can load `in` during the first 16 cycles of each block.

Parameters:
- LEN_W, 64, width of the internal bit-length counter. Must be ≤ 64; if smaller, the emitted length is zero-extended to 64 bits.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_data  in  32  message word, byte 0 in [31:24]
- in_bytes  in  3  valid bytes in in_data, MSB-aligned. Legal values: 4, or 0..4 when in_last=1.
- in_last  in  1  final word of message
- in_valid  in  1  input word offered
- in_ready  out  1  input word accepted when in_valid && in_ready
- out_data  out  32  padded stream word
- out_first  out  1  out_data is word 0 of a block
- out_final  out  1  out_data is word 15 of the message's last block
- out_valid  out  1  output word present
- out_ready  in  1  consumer takes word when out_valid && out_ready

Behaviour:
- Output register:
  - Single registered stage. out_* hold their values while out_valid && !out_ready.
  - Register loads when !out_valid || out_ready.
- Reset values: out_valid=0, out_data=0, out_first=0, out_final=0, in_ready=0, word index widx=0, bit length len=0, state=DATA.
- widx: 4-bit index of the next word to be emitted in the current block. Increments on each output load and wraps 15→0. out_first = (widx==0) at load time.
- State DATA:
  - in_ready = !out_valid || out_ready (combinational from registers and out_ready).
  - Latency: accepted word appears on out_data the next cycle.
  - On a non-last accept: out_data=in_data; len += 32.
  - On a last accept with in_bytes=k:
    - k<4: out_data = in_data bytes 0..k-1, then 0x80 at byte k, zeros below. len += 8k. Next state ZERO.
    - k=4: out_data=in_data; len += 32; next state PAD80.
    - k=0: in_data ignored and nothing is emitted this cycle; next state PAD80.
- State PAD80: emit 0x80000000. Next state ZERO.
- State ZERO:
  - Emit 0x00000000 until widx==14; then go to LENHI without emitting.
  - If the 0x80 word landed at index 14 or 15, zero-fill to 15, wrap into a new block, and zero-fill indices 0..13.
- State LENHI: emit len[63:32]. Next state LENLO.
- State LENLO:
  - Emit len[31:0] with out_final=1.
  - Then clear len to 0, set widx=0, and return to DATA.
- In every state other than DATA, in_ready=0.
- Pad states advance only when the output register loads. out_ready low stalls everything.
- No bubbles are required; a back-to-back next message may start the cycle after LENLO loads.
- len wraps modulo 2^LEN_W. Messages ≥ 2^(LEN_W-3) bytes are out of spec.
- Illegal in_bytes (5..7, or <4 without in_last) are out of spec. The bench checks with an assertion; no RTL recovery.
- Reset mid-message: all state is discarded immediately and out_valid drops asynchronously. The first accept after reset starts a fresh message at widx=0.

Decomposition:
- Shared package sha1_pkg:
  - SHA1_BLOCK_WORDS=16, SHA1_LEN_HI_IDX=14, SHA1_PAD_WORD=32'h80000000.
  - Pad state enum: DATA, PAD80, ZERO, LENHI, LENLO.
- Sub-module sha1_pad_mask: combinational; in_data plus in_bytes → masked word with the 0x80 marker inserted. Kept separate for unit test.

Test Plan:
- "abc": in_data=0x61626300, in_bytes=3, in_last → one block: 0x61626380, 13×0x00000000, 0x00000000, 0x00000018. out_first on word 0, out_final on word 15.
- Empty message: in_bytes=0, in_last → 0x80000000, 14 zeros, then word 15 = 0x00000000 with out_final.
- 56 bytes (14 words, last in_bytes=4) → block 1: data, 0x80000000, 0x00000000. Block 2: 14 zeros, 0x00000000, 0x000001C0. Exactly 32 words total.
- 64 bytes (16 full words) → block 1 = data with out_first on word 0 and no out_final. Block 2 = 0x80000000, 13 zeros, 0x00000000, 0x00000200.
- Random out_ready stalls on "abc" and the 56-byte case → identical word sequence. out_data stable whenever out_valid && !out_ready. No in_ready outside DATA.
- Assert rst_n low mid-block (widx=7) → out_valid=0 in the same cycle. A following "abc" message yields exactly the reference "abc" block.
